// File: rtl/testpattern_ctrl_if.sv
// Generator-side signals of testpattern_ctrl: VS feedback in, mode/colour/step out.
// master = sequencer, slave = pattern generator (or bench).
interface testpattern_ctrl_if;
  logic       I_vs;
  logic       I_vs_pol;
  logic [2:0] O_mode;
  logic [7:0] O_single_r;
  logic [7:0] O_single_g;
  logic [7:0] O_single_b;
  logic [3:0] O_step;
  logic       O_frame_start;

  modport master (
    input  I_vs, I_vs_pol,
    output O_mode, O_single_r, O_single_g, O_single_b, O_step, O_frame_start
  );

  modport slave (
    output I_vs, I_vs_pol,
    input  O_mode, O_single_r, O_single_g, O_single_b, O_step, O_frame_start
  );
endinterface

// File: rtl/testpattern_ctrl.sv
// Frame-synchronous test pattern step sequencer (debounced key, optional auto-advance).
// Define TESTPATTERN_CTRL_AUTO_EN to compile in the frame counter and auto-advance.
module testpattern_ctrl #(
  parameter logic [7:0]  FRAMES_PER_MODE = 8'd120,
  parameter logic [19:0] DEBOUNCE_CYC    = 20'd270000
) (
  input  logic               I_pxl_clk,
  input  logic               I_rst_n,
  input  logic               I_key_n,
  input  logic               I_auto_en,
  testpattern_ctrl_if.master tp
);

  typedef enum logic [0:0] {S_HOLD = 1'b0, S_APPLY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        key_meta_q, key_sync_q;
  logic        key_db_q, key_db_d, key_db_prev_q;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        req_pend_q, req_pend_d;
  logic        vs_prev_q;
  logic [3:0]  step_q, step_d;
  logic [2:0]  mode_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        frame_start_q;
  logic        vs_n_s, boundary_s, key_fall_s, auto_adv_s;
  logic [26:0] dec_s;

  // {mode, R, G, B} shown for a given step
  function automatic logic [26:0] step_decode(input logic [3:0] step);
    logic [26:0] v;
    case (step)
      4'd0:    v = {3'b000, 24'h000000};
      4'd1:    v = {3'b001, 24'h000000};
      4'd2:    v = {3'b010, 24'h000000};
      4'd3:    v = {3'b011, 24'hFFFFFF};
      4'd4:    v = {3'b011, 24'hFFFF00};
      4'd5:    v = {3'b011, 24'h00FFFF};
      4'd6:    v = {3'b011, 24'h00FF00};
      4'd7:    v = {3'b011, 24'hFF00FF};
      4'd8:    v = {3'b011, 24'hFF0000};
      4'd9:    v = {3'b011, 24'h0000FF};
      4'd10:   v = {3'b011, 24'h808080};
      default: v = {3'b000, 24'h000000};
    endcase
    return v;
  endfunction

  // The boundary is the end of the sync pulse, whatever its polarity
  assign vs_n_s     = tp.I_vs ^ tp.I_vs_pol;
  assign boundary_s = vs_n_s & ~vs_prev_q;
  assign key_fall_s = key_db_prev_q & ~key_db_q;

`ifdef TESTPATTERN_CTRL_AUTO_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign auto_adv_s = I_auto_en & (frame_cnt_q == (FRAMES_PER_MODE - 8'd1));

  // Saturating frame counter, restarted by every step advance
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == S_APPLY) begin
      frame_cnt_d = 8'd0;
    end else if (boundary_s && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) frame_cnt_q <= 8'd0;
    else          frame_cnt_q <= frame_cnt_d;
  end
`else
  logic unused_auto_en_s;
  assign unused_auto_en_s = I_auto_en;
  assign auto_adv_s       = 1'b0;
`endif

  // Debounce: accept a new level only after it has been stable long enough
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = db_cnt_q;
    if (key_sync_q == key_db_q) begin
      db_cnt_d = 20'd0;
    end else if (db_cnt_q == (DEBOUNCE_CYC - 20'd1)) begin
      key_db_d = key_sync_q;
      db_cnt_d = 20'd0;
    end else begin
      db_cnt_d = db_cnt_q + 20'd1;
    end
  end

  // Sequencer next state; a press arriving during S_APPLY wins over the clear
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    req_pend_d = req_pend_q;
    case (state_q)
      S_HOLD: begin
        if (boundary_s && (req_pend_q || auto_adv_s)) state_d = S_APPLY;
        else                                          state_d = S_HOLD;
      end
      S_APPLY: begin
        state_d = S_HOLD;
        step_d  = (step_q == 4'd10) ? 4'd0 : (step_q + 4'd1);
      end
      default: state_d = S_HOLD;
    endcase
    if (key_fall_s)              req_pend_d = 1'b1;
    else if (state_q == S_APPLY) req_pend_d = 1'b0;
    else                         req_pend_d = req_pend_q;
  end

  assign dec_s = step_decode(step_d);

  // All state and registered outputs
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      key_meta_q    <= 1'b1;
      key_sync_q    <= 1'b1;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= 20'd0;
      req_pend_q    <= 1'b0;
      vs_prev_q     <= 1'b1;
      state_q       <= S_HOLD;
      step_q        <= 4'd0;
      mode_q        <= 3'b000;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      key_meta_q    <= I_key_n;
      key_sync_q    <= key_meta_q;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
      req_pend_q    <= req_pend_d;
      vs_prev_q     <= vs_n_s;
      state_q       <= state_d;
      step_q        <= step_d;
      {mode_q, r_q, g_q, b_q} <= dec_s;
      frame_start_q <= boundary_s;
    end
  end

  assign tp.O_mode        = mode_q;
  assign tp.O_single_r    = r_q;
  assign tp.O_single_g    = g_q;
  assign tp.O_single_b    = b_q;
  assign tp.O_step        = step_q;
  assign tp.O_frame_start = frame_start_q;

endmodule
